// File: rtl/lif_layer_scheduler.sv
// lif_layer_scheduler
// Steps N_NEURONS leaky integrate-and-fire neurons through one shared adder
// tree, one neuron per cycle. Each visited neuron's packed 2-bit input
// fields are summed. The membrane is then leaked, integrated, saturated and
// compared against the threshold.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request one integration step (accepted only when idle)
//   threshold  firing threshold, sampled on every RUN cycle
//   neuron_idx registered index of the neuron whose wx is consumed
//   wx         packed 2-bit inputs for neuron_idx (combinational source)
//   busy       high while a step is in flight (RUN and DONE)
//   done       one-cycle pulse; spikes are valid from this cycle on
//   spikes     bit i = neuron i fired in the last completed step
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | consuming wx for neuron_idx, one neuron per cycle
// DONE   | step finished; done pulses on the way back to IDLE
module lif_layer_scheduler #(
  parameter  int N_STAGE    = 5,
  parameter  int N_NEURONS  = 4,
  parameter  int U_W        = 8,
  parameter  int LEAK_SHIFT = 1,
  localparam int WX_W  = 2 ** (N_STAGE + 1),
  localparam int S_W   = N_STAGE + 2,
  localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [U_W-1:0]       threshold,
  output logic [IDX_W-1:0]     neuron_idx,
  input  logic [WX_W-1:0]      wx,
  output logic                 busy,
  output logic                 done,
  output logic [N_NEURONS-1:0] spikes
);

  localparam int N_FIELDS = 2 ** N_STAGE;
  // One guard bit above the wider operand so integration cannot wrap.
  localparam int C_W = ((U_W > S_W) ? U_W : S_W) + 1;
  localparam logic [C_W-1:0]   U_MAX = {{(C_W - U_W){1'b0}}, {U_W{1'b1}}};
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state;
  logic [U_W-1:0] u_mem [N_NEURONS];

  logic [S_W-1:0] tree_sum;
  logic [U_W-1:0] u_cur;
  logic [U_W-1:0] leak;
  logic [C_W-1:0] u_ext;
  logic [U_W-1:0] u_next;
  logic           fire;

  always_comb begin
    tree_sum = '0;
    for (int f = 0; f < N_FIELDS; f++) begin
      tree_sum = tree_sum + S_W'(wx[2*f +: 2]);
    end
  end

  always_comb begin
    u_cur = u_mem[neuron_idx];
    // A shift of U_W or more would clear u entirely; treat it as "no leak".
    if (LEAK_SHIFT >= U_W) leak = '0;
    else                   leak = u_cur >> LEAK_SHIFT;
    // leak <= u_cur, so the subtraction never underflows.
    u_ext  = C_W'(u_cur) - C_W'(leak) + C_W'(tree_sum);
    u_next = (u_ext > U_MAX) ? U_MAX[U_W-1:0] : u_ext[U_W-1:0];
    fire   = (u_next >= threshold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      neuron_idx <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      spikes     <= '0;
      for (int i = 0; i < N_NEURONS; i++) u_mem[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_RUN;
            neuron_idx <= '0;
            busy       <= 1'b1;
          end
        end
        S_RUN: begin
          spikes[neuron_idx] <= fire;
          u_mem[neuron_idx]  <= fire ? '0 : u_next;
          if (neuron_idx == LAST) begin
            state      <= S_DONE;
            neuron_idx <= '0;
          end else begin
            neuron_idx <= neuron_idx + 1'b1;
          end
        end
        S_DONE: begin
          // done lands in the first IDLE cycle; start is only accepted
          // at the edge after that one.
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state      <= S_IDLE;
          neuron_idx <= '0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lif_layer_scheduler.sv
module tb_lif_layer_scheduler;

  localparam int NN  = 4;
  localparam int LAT = NN + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  threshold = '0;
  logic [63:0] wx_tab [NN];
  logic [63:0] wx0, wx1;
  logic [1:0]  idx0, idx1;
  logic        busy0, busy1, done0, done1;
  logic [3:0]  spk0, spk1;

  int          errors = 0;
  int          checks = 0;
  int          mu [2][NN];
  logic [3:0]  mspk [2];

  always #5 clk = ~clk;

  assign wx0 = wx_tab[idx0];
  assign wx1 = wx_tab[idx1];

  lif_layer_scheduler #(.N_STAGE(5), .N_NEURONS(4), .U_W(8), .LEAK_SHIFT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .threshold(threshold),
    .neuron_idx(idx0), .wx(wx0), .busy(busy0), .done(done0), .spikes(spk0));

  lif_layer_scheduler #(.N_STAGE(5), .N_NEURONS(4), .U_W(8), .LEAK_SHIFT(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .threshold(threshold),
    .neuron_idx(idx1), .wx(wx1), .busy(busy1), .done(done1), .spikes(spk1));

  // ---------------- reference model ----------------
  function automatic int fsum(input logic [63:0] v);
    int s = 0;
    for (int f = 0; f < 32; f++) s += int'(v[2*f +: 2]);
    return s;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      mspk[d] = '0;
      for (int i = 0; i < NN; i++) mu[d][i] = 0;
    end
  endtask

  task automatic model_step(input int thr);
    int ls, un;
    for (int d = 0; d < 2; d++) begin
      ls = (d == 0) ? 1 : 8;
      for (int i = 0; i < NN; i++) begin
        un = mu[d][i] - (mu[d][i] >> ls) + fsum(wx_tab[i]);
        if (un > 255) un = 255;
        if (un >= thr) begin
          mspk[d][i] = 1'b1;
          mu[d][i]   = 0;
        end else begin
          mspk[d][i] = 1'b0;
          mu[d][i]   = un;
        end
      end
    end
  endtask

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // Issues one start and returns the number of edges from the accepting
  // edge (counted as 1) to the edge after which done is seen; 50 = timeout.
  task automatic run_step(output int n);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done0 && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic set_all(input logic [63:0] v);
    for (int i = 0; i < NN; i++) wx_tab[i] = v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    #1;
    checks++;
    if ({busy0, done0, idx0, spk0, busy1, done1, idx1, spk1} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b idx=%0d spk=%b exp all zero",
               busy0, done0, idx0, spk0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    set_all({64{1'b1}});
    threshold = 8'd255;
    run_step(n);
    model_step(255);
    // Start a step that fires, then reset after two RUN edges.
    threshold = 8'd0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (busy0 !== 1'b1 || spk0[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_run got busy=%b spk=%b exp busy=1 spk[0]=1", busy0, spk0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy0, idx0, spk0, busy1, idx1, spk1} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run got busy=%b idx=%0d spk=%b exp all zero", busy0, idx0, spk0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    threshold = 8'd200;
    run_step(n);
    model_step(200);
    checks++;
    if ({spk1, spk0} !== {mspk[1], mspk[0]}) begin
      errors++;
      $display("FAIL reset_step1 got %b_%b exp %b_%b", spk1, spk0, mspk[1], mspk[0]);
    end
    threshold = 8'd150;
    run_step(n);
    model_step(150);
    checks++;
    if ({spk1, spk0} !== {mspk[1], mspk[0]}) begin
      errors++;
      $display("FAIL reset_step2 got %b_%b exp %b_%b", spk1, spk0, mspk[1], mspk[0]);
    end
  endtask

  task automatic test_defaults();
    int n;
    do_reset();
    set_all({64{1'b1}});
    threshold = 8'd100;
    for (int s = 0; s < 2; s++) begin
      run_step(n);
      model_step(100);
      checks++;
      if (n != LAT || done1 !== 1'b1) begin
        errors++;
        $display("FAIL defaults_latency step%0d got %0d exp %0d", s, n, LAT);
      end
      checks++;
      if ({spk1, spk0} !== {mspk[1], mspk[0]}) begin
        errors++;
        $display("FAIL defaults_spikes step%0d got %b_%b exp %b_%b", s, spk1, spk0, mspk[1], mspk[0]);
      end
      @(negedge clk);
      checks++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL defaults_done_width got done=%b busy=%b exp 0 0", done0, busy0);
      end
    end
  endtask

  task automatic test_independence();
    int n;
    do_reset();
    wx_tab[0] = {64{1'b1}};
    wx_tab[1] = '0;
    wx_tab[2] = {64{1'b1}};
    wx_tab[3] = '0;
    threshold = 8'd100;
    for (int s = 0; s < 2; s++) begin
      run_step(n);
      model_step(100);
    end
    checks++;
    if ({spk1, spk0} !== {mspk[1], mspk[0]}) begin
      errors++;
      $display("FAIL independence got %b_%b exp %b_%b", spk1, spk0, mspk[1], mspk[0]);
    end
  endtask

  task automatic test_saturation();
    int n;
    do_reset();
    set_all({64{1'b1}});
    threshold = 8'd255;
    for (int s = 0; s < 3; s++) begin
      run_step(n);
      model_step(255);
      checks++;
      if ({spk1, spk0} !== {mspk[1], mspk[0]}) begin
        errors++;
        $display("FAIL saturation step%0d got %b_%b exp %b_%b", s, spk1, spk0, mspk[1], mspk[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, cyc, prev;
    do_reset();
    for (int i = 0; i < NN; i++) wx_tab[i] = {$urandom, $urandom};
    threshold = 8'($urandom_range(60, 200));
    start = 1'b1;
    cyc = 0;
    prev = -1;
    for (int s = 0; s < 4; s++) begin
      n = 0;
      do begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
        n++;
      end while (!done0 && n < 50);
      model_step(int'(threshold));
      checks++;
      if ({spk1, spk0} !== {mspk[1], mspk[0]}) begin
        errors++;
        $display("FAIL b2b_spikes step%0d got %b_%b exp %b_%b", s, spk1, spk0, mspk[1], mspk[0]);
      end
      if (prev >= 0) begin
        checks++;
        if (cyc - prev != LAT) begin
          errors++;
          $display("FAIL b2b_period got %0d exp %0d", cyc - prev, LAT);
        end
      end
      prev = cyc;
      if (s == 3) start = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop got done=%b busy=%b exp 0 0", done0, busy0);
    end
    // A start pulse mid-RUN must neither shorten nor queue a step.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    @(posedge clk);
    @(negedge clk);
    n++;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n++;
    start = 1'b0;
    while (!done0 && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    model_step(int'(threshold));
    checks++;
    if (n != LAT || {spk1, spk0} !== {mspk[1], mspk[0]}) begin
      errors++;
      $display("FAIL midrun_start got lat=%0d spk=%b_%b exp lat=%0d spk=%b_%b",
               n, spk1, spk0, LAT, mspk[1], mspk[0]);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_queue got busy=%b exp 0", busy0);
    end
  endtask

  task automatic test_thr_zero();
    int n;
    do_reset();
    set_all('0);
    threshold = 8'd0;
    for (int s = 0; s < 3; s++) begin
      run_step(n);
      model_step(0);
      checks++;
      if ({spk1, spk0} !== {mspk[1], mspk[0]}) begin
        errors++;
        $display("FAIL thr_zero step%0d got %b_%b exp %b_%b", s, spk1, spk0, mspk[1], mspk[0]);
      end
    end
  endtask

  task automatic test_random();
    int n, thr;
    for (int s = 0; s < 10; s++) begin
      for (int i = 0; i < NN; i++)
        wx_tab[i] = {$urandom, $urandom} & {$urandom, $urandom};
      thr = $urandom_range(0, 255);
      threshold = 8'(thr);
      run_step(n);
      model_step(thr);
      checks++;
      if (n != LAT || {spk1, spk0} !== {mspk[1], mspk[0]}) begin
        errors++;
        $display("FAIL random step%0d got lat=%0d spk=%b_%b exp lat=%0d spk=%b_%b",
                 s, n, spk1, spk0, LAT, mspk[1], mspk[0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    set_all('0);
    model_clear();
    test_reset();
    test_defaults();
    test_independence();
    test_saturation();
    test_back_to_back();
    test_thr_zero();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
